// File: rtl/fifo_write_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_ctrl_param
// Brief    : Write-side FIFO controller. Gates producer writes against full,
//            drives the registered RAM write port and tracks occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_ctrl_param #(
  parameter int ADDR_W   = 4,
  parameter int AFULL_TH = (2 ** ADDR_W) - 2
) (
  input  logic              i_clk,
  input  logic              i_rest,
  input  logic              i_wen,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic              i_clr_ovf,
  output logic              o_wen_ctrl,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [ADDR_W:0]   o_wptr,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_afull,
  output logic              o_ovf
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_V   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_V = AFULL_TH[ADDR_W:0];

  logic              wen_q,   wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   wptr_q,  wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q,   ovf_d;

  logic w_full;
  logic w_accept;
  logic w_pop_v;

  // Flags depend only on registered occupancy to keep i_wen/i_pop off the path.
  assign w_full   = (count_q == DEPTH_V);
  assign w_accept = i_wen & ~w_full & ~i_flush;
  assign w_pop_v  = i_pop & (count_q != '0);

  always_comb begin
    wen_d   = w_accept;
    waddr_d = waddr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (w_accept) begin
      waddr_d = wptr_q[ADDR_W-1:0];
      wptr_d  = wptr_q + ONE_V;
    end

    if (w_accept && !w_pop_v) begin
      count_d = count_q + ONE_V;
    end else if (!w_accept && w_pop_v) begin
      count_d = count_q - ONE_V;
    end

    if (i_flush) begin
      wptr_d  = '0;
      count_d = '0;
    end

    // Set has priority over clear.
    if (i_wen && w_full && !i_flush) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_wen_ctrl = wen_q;
  assign o_waddr    = waddr_q;
  assign o_wptr     = wptr_q;
  assign o_count    = count_q;
  assign o_full     = w_full;
  assign o_afull    = (count_q >= AFULL_V);
  assign o_ovf      = ovf_q;

endmodule
`default_nettype wire
